// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: tracks in-flight destination registers across
// FWD_DEPTH stages after decode. Optional stall counter enabled by HAZARD_PERF_EN.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_LAT   = 1,
  parameter int ZERO_REG   = 31,
  localparam int FSEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_rn_used,
  input  logic                  id_rm_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic [FSEL_W-1:0]     fwd_a,
  output logic [FSEL_W-1:0]     fwd_b,
`ifdef HAZARD_PERF_EN
  output logic [31:0]           stall_cycles,
`endif
  output logic [NUM_REGS-1:0]   pending_mask
);

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);
  localparam logic [NUM_REGS-1:0]   ONE_HOT0  = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [FWD_DEPTH-1:0]  valid_q, valid_d;
  logic [FWD_DEPTH-1:0]  regwrite_q, regwrite_d;
  logic [FWD_DEPTH-1:0]  is_load_q, is_load_d;
  logic [REG_ADDR_W-1:0] rd_q [FWD_DEPTH];
  logic [REG_ADDR_W-1:0] rd_d [FWD_DEPTH];

  logic [FWD_DEPTH-1:0]  match_a_s, match_b_s;
  logic                  hazard_s;
  logic                  stall_s;
  logic [FSEL_W-1:0]     fwd_a_s, fwd_b_s;
  logic [NUM_REGS-1:0]   pending_s;

  // Operand match against each tracked entry, priority select and load-use hazard.
  always_comb begin
    match_a_s = '0;
    match_b_s = '0;
    fwd_a_s   = '0;
    fwd_b_s   = '0;
    hazard_s  = 1'b0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      match_a_s[k] = valid_q[k] & regwrite_q[k] & (rd_q[k] == id_rn) &
                     (id_rn != ZERO_ADDR) & id_rn_used;
      match_b_s[k] = valid_q[k] & regwrite_q[k] & (rd_q[k] == id_rm) &
                     (id_rm != ZERO_ADDR) & id_rm_used;
    end
    // Walk oldest to youngest so the youngest matching producer wins.
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      fwd_a_s = match_a_s[k] ? FSEL_W'(k + 1) : fwd_a_s;
      fwd_b_s = match_b_s[k] ? FSEL_W'(k + 1) : fwd_b_s;
    end
    for (int k = 0; k < LOAD_LAT; k++) begin
      hazard_s = hazard_s | ((match_a_s[k] | match_b_s[k]) & is_load_q[k]);
    end
    stall_s = id_valid & ~flush & hazard_s;
  end

  // Pending-write mask: one-hot OR of every valid writing entry, XZR included.
  always_comb begin
    pending_s = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      pending_s = pending_s |
                  ((valid_q[k] & regwrite_q[k]) ? (ONE_HOT0 << rd_q[k]) : '0);
    end
  end

  // Next state of the tracking shift register; stalls and flushes inject a bubble.
  always_comb begin
    valid_d[0]    = id_valid & ~flush & ~stall_s;
    regwrite_d[0] = id_regwrite;
    is_load_d[0]  = id_is_load;
    rd_d[0]       = id_rd;
    for (int i = 1; i < FWD_DEPTH; i++) begin
      valid_d[i]    = valid_q[i-1];
      regwrite_d[i] = regwrite_q[i-1];
      is_load_d[i]  = is_load_q[i-1];
      rd_d[i]       = rd_q[i-1];
    end
  end

  // Tracking shift register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      is_load_q  <= '0;
      for (int i = 0; i < FWD_DEPTH; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      is_load_q  <= is_load_d;
      rd_q       <= rd_d;
    end
  end

  assign stall        = stall_s;
  assign fwd_a        = fwd_a_s;
  assign fwd_b        = fwd_b_s;
  assign pending_mask = pending_s;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating stall counter next value.
  always_comb begin
    if (stall_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the pipelined ARM-subset CPU.
- Sits beside the decode stage and tracks in-flight destination registers across FWD_DEPTH downstream stages in an internal shift register.
- Produces per-operand forwarding selects, load-use stalls, a decode-stage bubble on flush, and a pending-write register mask.
- Generalises the fixed two-stage forwarding check with configurable depth, load latency, zero-register exclusion and an optional stall-cycle counter.

Parameters:
REG_ADDR_W, 5, register-number width
NUM_REGS, 32, architectural register count
FWD_DEPTH, 3, tracked stages after decode (stage 1 = EX, 2 = MEM, 3 = WB)
LOAD_LAT, 1, stage index before which load data is unavailable (1..FWD_DEPTH-1)
ZERO_REG, 31, register never hazarded or forwarded (XZR)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
id_valid  input  1  decode slot holds a real instruction
id_rn  input  REG_ADDR_W  operand A source register
id_rm  input  REG_ADDR_W  operand B source register (post Reg2Loc mux)
id_rn_used  input  1  operand A is read
id_rm_used  input  1  operand B is read
id_rd  input  REG_ADDR_W  destination register (post X30 mux)
id_regwrite  input  1  decoded instruction writes id_rd
id_is_load  input  1  decoded instruction is LDUR
flush  input  1  discard decode-stage instruction (taken branch)
stall  output  1  hold PC and IF/ID; insert bubble into ID/EX
fwd_a  output  FSEL_W  operand A select, FSEL_W = $clog2(FWD_DEPTH+1)
fwd_b  output  FSEL_W  operand B select
pending_mask  output  NUM_REGS  bit r set when any valid tracked entry writes r
stall_cycles  output  32  saturating stall counter (present only with macro)

Behaviour:
- Storage: entry[0..FWD_DEPTH-1], each holding {valid, rd, regwrite, is_load}. entry[0] is EX.
- Reset (reset low, asynchronous): all entries cleared, valid = 0. Outputs return to 0 immediately: stall, fwd_a, fwd_b, pending_mask and stall_cycles.
- match_X(k) = entry[k-1].valid & entry[k-1].regwrite & entry[k-1].rd == id_X & id_X != ZERO_REG & id_X_used.
- fwd_X selects the smallest k in 1..FWD_DEPTH with match_X(k), else 0 (register file). The youngest producer wins when several entries match.
- Encoding: 0 = RF, 1 = ALU out, 2 = MEM result, 3 = WB data.
- hazard = any operand X and any k <= LOAD_LAT with match_X(k) & entry[k-1].is_load.
- stall = id_valid & ~flush & hazard. Combinational, no added latency.
- While stall = 1, fwd_a and fwd_b still reflect the current state. The consumer ignores them because a bubble is inserted.
- Rising edge, when not in reset:
  - entry[i] <= entry[i-1] for i >= 1. Entries always advance; downstream stages never stall.
  - entry[0] <= {id_valid & ~flush & ~stall, id_rd, id_regwrite, id_is_load}.
  - When stall or flush is set, entry[0] becomes a bubble with valid = 0.
- flush and stall together: flush wins, stall = 0, and a bubble is inserted.
- Writes to ZERO_REG are tracked in pending_mask but never cause forwarding or a stall.
- id_regwrite = 0 entries never match, even when rd equals a source register.
- A stall lasts exactly LOAD_LAT cycles for one load-use pair, then the load data is forwarded from stage LOAD_LAT+1.
- pending_mask is the OR over valid & regwrite entries of the one-hot decode of rd.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: stall_cycles exists. It resets to 0, increments on each rising edge where stall = 1, and saturates at 32'hFFFF_FFFF. Flush cycles are not counted.
- Undefined: the stall_cycles port and the counter are omitted. All other behaviour is identical.

Test Plan:
- Reset mid-stream: fill all 3 entries with writes to X1..X3, then pull reset low between edges. Required: pending_mask = 0 and fwd_a = fwd_b = 0 immediately, with no wait for an edge.
- Back-to-back ALU dependency: ADDI X2 issued, next cycle ADD X3,X2,X2. Required: fwd_a = fwd_b = 1, stall = 0. One cycle later a user of X2 sees fwd = 2.
- Load-use: LDUR X5 then SUB X6,X5,X7 (rm used). Required: stall = 1 for exactly 1 cycle, then fwd_a = 2, fwd_b = 0. stall_cycles = 1 (macro on).
- Priority: entry[0] and entry[2] both write X4, consumer reads X4. Required: fwd_a = 1.
- XZR and non-writers: producer writes X31 and STUR sources X9 with regwrite = 0. Required: fwd = 0, stall = 0, pending_mask[31] = 1.
- Flush with hazard: LDUR X5 in entry[0], consumer of X5 in decode with flush = 1. Required: stall = 0, next entry[0].valid = 0, stall_cycles unchanged.
